cic_decimator_mc: RTL and testbench

Multi-channel, runtime-configurable CIC decimator. It is the successor to the single-channel fixed-ratio decimator in the PDM microphone path. One time-multiplexed integrator/comb datapath serves CHANNELS interleaved streams, for example a stereo PDM pair. Decimation ratio and gain shift are loaded at runtime. Output is ready/valid with backpressure, and accumulators are sized for full bit growth.

---
 rtl/cic_mc_pkg.sv | 20 ++
 rtl/cic_round_sat.sv | 43 ++++
 rtl/cic_decimator_mc.sv | 178 +++++++++++++++++
 tb/tb_cic_decimator_mc.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_mc_pkg.sv
// Shared types and helpers for the multi-channel CIC decimator.
// Holds the FSM state encoding and accumulator sizing.
package cic_mc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    INT,
    COMB,
    OUT
  } cic_state_e;

  function automatic int cic_acc_width(
    input int in_w,
    input int n,
    input int r_max
  );
    return in_w + n * $clog2(r_max);
  endfunction

endpackage

// File: rtl/cic_round_sat.sv
// Round half-up, arithmetic right shift and saturate
// a wide CIC accumulator value down to the output width.
module cic_round_sat #(
  parameter int ACC_WIDTH = 40,
  parameter int OUT_WIDTH = 16,
  parameter int SH_W      = $clog2(ACC_WIDTH)
) (
  input  logic signed [ACC_WIDTH-1:0] value,
  input  logic        [SH_W-1:0]      shift,
  output logic signed [OUT_WIDTH-1:0] result
);

  localparam int EW = ACC_WIDTH + 1;

  localparam logic signed [EW-1:0] MAXV =
    {{(EW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] MINV =
    {{(EW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] half;
  logic signed [EW-1:0] sum;
  logic signed [EW-1:0] shifted;

  // one guard bit keeps the rounding add from wrapping
  always_comb begin
    ext  = {value[ACC_WIDTH-1], value};
    half = '0;
    if (shift != '0) begin
      half = EW'(1) << (shift - 1'b1);
    end
    sum     = ext + half;
    shifted = sum >>> shift;
    if (shifted > MAXV) begin
      result = MAXV[OUT_WIDTH-1:0];
    end else if (shifted < MINV) begin
      result = MINV[OUT_WIDTH-1:0];
    end else begin
      result = shifted[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/cic_decimator_mc.sv
// Time-multiplexed N-stage CIC decimator serving several interleaved
// channels with runtime ratio/shift and a ready/valid output.
module cic_decimator_mc
  import cic_mc_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int N         = 4,
  parameter int R_MAX     = 64,
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 16,
  localparam int ACC_WIDTH = cic_acc_width(IN_WIDTH, N, R_MAX),
  localparam int R_W  = $clog2(R_MAX) + 1,
  localparam int SH_W = $clog2(ACC_WIDTH),
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_load,
  input  logic [R_W-1:0]               cfg_r,
  input  logic [SH_W-1:0]              cfg_shift,
  output logic                         cfg_err,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*IN_WIDTH-1:0] in_sample,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CH_W-1:0]              out_channel,
  output logic signed [OUT_WIDTH-1:0]  out_sample
);

  cic_state_e state;

  logic [CH_W-1:0] ch;
  logic [R_W-1:0]  r_q;
  logic [R_W-1:0]  dcnt;
  logic [SH_W-1:0] sh_q;

  logic signed [IN_WIDTH-1:0]  frame_q [CHANNELS];
  logic signed [ACC_WIDTH-1:0] integ   [CHANNELS][N];
  logic signed [ACC_WIDTH-1:0] dly     [CHANNELS][N];

  logic signed [IN_WIDTH-1:0]  xs;
  logic signed [ACC_WIDTH-1:0] x_ext;
  logic signed [ACC_WIDTH-1:0] integ_nxt [N];
  logic signed [ACC_WIDTH-1:0] comb_c    [N+1];
  logic signed [OUT_WIDTH-1:0] rs_out;

  logic last_ch;
  logic last_dec;
  logic cfg_ok;

  assign xs    = frame_q[ch];
  assign x_ext = {{(ACC_WIDTH-IN_WIDTH){xs[IN_WIDTH-1]}}, xs};

  assign last_ch  = (ch == CH_W'(CHANNELS - 1));
  assign last_dec = (dcnt == r_q - R_W'(1));

  assign cfg_ok = (cfg_r >= R_W'(2))
               && (cfg_r <= R_W'(R_MAX))
               && (cfg_shift <= SH_W'(ACC_WIDTH - OUT_WIDTH));

  assign in_ready = rst_n && (state == IDLE) && !cfg_load;

  // integrators read old values of the previous stage
  for (genvar g = 0; g < N; g++) begin : g_int
    if (g == 0) begin : g_first
      assign integ_nxt[g] = integ[ch][g] + x_ext;
    end else begin : g_rest
      assign integ_nxt[g] = integ[ch][g] + integ[ch][g-1];
    end
  end

  assign comb_c[0] = integ[ch][N-1];

  for (genvar g = 0; g < N; g++) begin : g_comb
    assign comb_c[g+1] = comb_c[g] - dly[ch][g];
  end

  cic_round_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .SH_W      (SH_W)
  ) u_round_sat (
    .value  (comb_c[N]),
    .shift  (sh_q),
    .result (rs_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ch          <= '0;
      dcnt        <= '0;
      r_q         <= R_W'(R_MAX);
      sh_q        <= SH_W'(N * $clog2(R_MAX));
      cfg_err     <= 1'b0;
      out_valid   <= 1'b0;
      out_channel <= '0;
      out_sample  <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        frame_q[c] <= '0;
        for (int g = 0; g < N; g++) begin
          integ[c][g] <= '0;
          dly[c][g]   <= '0;
        end
      end
    end else begin
      if (cfg_load) begin
        if (state == IDLE && cfg_ok) begin
          r_q     <= cfg_r;
          sh_q    <= cfg_shift;
          dcnt    <= '0;
          cfg_err <= 1'b0;
          for (int c = 0; c < CHANNELS; c++) begin
            for (int g = 0; g < N; g++) begin
              integ[c][g] <= '0;
              dly[c][g]   <= '0;
            end
          end
        end else begin
          cfg_err <= 1'b1;
        end
      end

      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            for (int c = 0; c < CHANNELS; c++) begin
              frame_q[c] <= in_sample[c*IN_WIDTH +: IN_WIDTH];
            end
            ch    <= '0;
            state <= INT;
          end
        end
        INT: begin
          for (int g = 0; g < N; g++) begin
            integ[ch][g] <= integ_nxt[g];
          end
          if (last_ch) begin
            ch <= '0;
            if (last_dec) begin
              dcnt  <= '0;
              state <= COMB;
            end else begin
              dcnt  <= dcnt + R_W'(1);
              state <= IDLE;
            end
          end else begin
            ch <= ch + 1'b1;
          end
        end
        COMB: begin
          for (int g = 0; g < N; g++) begin
            dly[ch][g] <= comb_c[g];
          end
          out_sample  <= rs_out;
          out_channel <= ch;
          out_valid   <= 1'b1;
          state       <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last_ch) begin
              ch    <= '0;
              state <= IDLE;
            end else begin
              ch    <= ch + 1'b1;
              state <= COMB;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cic_decimator_mc.sv
// Randomized bench for cic_decimator_mc against a direct-form
// FIR model of the CIC (boxcar^N kernel applied to input history).
module tb_cic_decimator_mc;

  localparam int CH   = 2;
  localparam int NS   = 4;
  localparam int RMAX = 64;
  localparam int IW   = 16;
  localparam int OW   = 16;
  localparam int RW   = 7;
  localparam int SW   = 6;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 cfg_load = 1'b0;
  logic [RW-1:0]        cfg_r = 7'd8;
  logic [SW-1:0]        cfg_shift = 6'd12;
  logic                 cfg_err;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [CH*IW-1:0]     in_sample = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [0:0]           out_channel;
  logic signed [OW-1:0] out_sample;

  always #5 clk = ~clk;

  cic_decimator_mc #(
    .CHANNELS  (CH),
    .N         (NS),
    .R_MAX     (RMAX),
    .IN_WIDTH  (IW),
    .OUT_WIDTH (OW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_load    (cfg_load),
    .cfg_r       (cfg_r),
    .cfg_shift   (cfg_shift),
    .cfg_err     (cfg_err),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sample   (in_sample),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_channel (out_channel),
    .out_sample  (out_sample)
  );

  int     n_checks = 0;
  int     n_err = 0;
  int     cur_r;
  int     cur_sh;
  bit     exp_err;
  int     nfr;
  int     hist [CH][$];
  longint h [$];
  int     exp_s [$];
  int     exp_c [$];
  int     last_out [CH];
  bit     hold_ready = 1'b0;

  task automatic check(input string tag, input longint got,
                       input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // CIC impulse response: R-tap boxcar convolved with itself N times
  task automatic model_cfg(input int r, input int s);
    longint t [$];
    cur_r  = r;
    cur_sh = s;
    nfr    = 0;
    for (int c = 0; c < CH; c++) hist[c].delete();
    h = {64'sd1};
    repeat (NS) begin
      t = {};
      for (int i = 0; i < h.size() + r - 1; i++) t.push_back(0);
      for (int i = 0; i < h.size(); i++)
        for (int j = 0; j < r; j++) t[i+j] += h[i];
      h = t;
    end
  endtask

  function automatic longint round_sat(input longint y, input int s);
    longint v;
    v = y;
    if (s > 0) v += (longint'(1) << (s - 1));
    v = v >>> s;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  // integrator cascade adds NS-1 frames of pipeline delay
  task automatic record_frame(input logic [CH*IW-1:0] f);
    longint y;
    int idx;
    for (int c = 0; c < CH; c++)
      hist[c].push_back(int'($signed(f[c*IW +: IW])));
    nfr++;
    if (nfr % cur_r == 0) begin
      for (int c = 0; c < CH; c++) begin
        y = 0;
        for (int k = 0; k < h.size(); k++) begin
          idx = nfr - 1 - (NS - 1) - k;
          if (idx >= 0) y += h[k] * longint'(hist[c][idx]);
        end
        exp_s.push_back(int'(round_sat(y, cur_sh)));
        exp_c.push_back(c);
      end
    end
  endtask

  task automatic send_frame(input logic [CH*IW-1:0] f);
    in_sample = f;
    in_valid  = 1'b1;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (in_ready) begin
        record_frame(f);
        step();
        in_valid = 1'b0;
        return;
      end
      step();
    end
    check("frame_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic run(input int nf, input bit dc, input int a,
                     input int b);
    logic [CH*IW-1:0] f;
    for (int i = 0; i < nf; i++) begin
      if (dc) f = {IW'(b), IW'(a)};
      else f = $urandom;
      if ($urandom_range(3) == 0) step();
      send_frame(f);
    end
  endtask

  task automatic wait_ready(input string tag);
    for (int t = 0; t < 3000 && !in_ready; t++) step();
    check(tag, in_ready, 1);
  endtask

  task automatic load_cfg(input int r, input int s);
    wait_ready("cfg_wait_idle");
    cfg_load  = 1'b1;
    cfg_r     = RW'(r);
    cfg_shift = SW'(s);
    step();
    cfg_load = 1'b0;
    if (r >= 2 && r <= RMAX && s >= 0 && s <= 24) begin
      model_cfg(r, s);
      exp_err = 1'b0;
    end else begin
      exp_err = 1'b1;
    end
    check("cfg_err_load", cfg_err, exp_err);
  endtask

  task automatic drain();
    for (int t = 0; t < 3000; t++) begin
      if (exp_s.size() == 0 && in_ready) break;
      step();
    end
    check("drain_pending", exp_s.size(), 0);
  endtask

  task automatic wait_out(input string tag);
    for (int t = 0; t < 500 && !out_valid; t++) step();
    check(tag, out_valid, 1);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = hold_ready ? 1'b0 : ($urandom_range(3) != 0);
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_s.size() == 0) begin
        check("unexpected_out", out_sample, 0);
        check("unexpected_out_any", 1, 0);
      end else begin
        check("out_channel", out_channel, exp_c[0]);
        check("out_sample", out_sample, exp_s[0]);
        last_out[exp_c[0]] = out_sample;
        void'(exp_s.pop_front());
        void'(exp_c.pop_front());
      end
    end
  end

  initial begin
    int r;
    int s;
    repeat (3) step();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_channel", out_channel, 0);
    check("rst_out_sample", out_sample, 0);
    check("rst_cfg_err", cfg_err, 0);
    rst_n = 1'b1;
    model_cfg(RMAX, 24);
    exp_err = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    run(2 * RMAX, 1'b0, 0, 0);
    drain();

    load_cfg(8, 12);
    run(48, 1'b1, 1000, -1000);
    drain();
    check("dc_ch0", last_out[0], 1000);
    check("dc_ch1", last_out[1], -1000);

    repeat (3) begin
      r = $urandom_range(2, RMAX);
      s = $urandom_range(0, 24);
      load_cfg(r, s);
      run(3 * r + $urandom_range(0, r), 1'b0, 0, 0);
      drain();
    end

    load_cfg(8, 10);
    run(48, 1'b1, 16000, -16000);
    drain();
    check("sat_ch0", last_out[0], 32767);
    check("sat_ch1", last_out[1], -32768);

    load_cfg(2, 5);
    run(20, 1'b1, 1, 1);
    drain();
    check("round_sh5", last_out[0], 1);
    load_cfg(2, 6);
    run(20, 1'b1, 1, 1);
    drain();
    check("round_sh6", last_out[0], 0);

    load_cfg(8, 12);
    run(7, 1'b0, 0, 0);
    hold_ready = 1'b1;
    run(1, 1'b0, 0, 0);
    wait_out("bp_wait_out");
    in_sample = $urandom;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      if (exp_s.size() > 0) begin
        check("bp_out_sample", out_sample, exp_s[0]);
        check("bp_out_channel", out_channel, exp_c[0]);
      end
      step();
    end
    in_valid   = 1'b0;
    hold_ready = 1'b0;
    drain();

    load_cfg(1, 12);
    run(16, 1'b0, 0, 0);
    drain();

    run(8, 1'b0, 0, 0);
    wait_out("mist_wait_out");
    cfg_load  = 1'b1;
    cfg_r     = RW'(4);
    cfg_shift = SW'(8);
    step();
    cfg_load = 1'b0;
    check("cfg_err_in_out", cfg_err, 1);
    drain();
    load_cfg(8, 12);
    run(16, 1'b1, 1000, -1000);
    drain();

    run(7, 1'b1, 1000, -1000);
    send_frame({IW'(-1000), IW'(1000)});
    step();
    step();
    rst_n = 1'b0;
    step();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    exp_s.delete();
    exp_c.delete();
    step();
    rst_n = 1'b1;
    model_cfg(RMAX, 24);
    exp_err = 1'b0;
    #1;
    check("midrst_rel_in_ready", in_ready, 1);
    check("midrst_cfg_err", cfg_err, 0);
    load_cfg(8, 12);
    run(8, 1'b1, 1000, -1000);
    drain();
    check("fresh_ch0", last_out[0], 17);
    check("fresh_ch1", last_out[1], -17);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
